// File: rtl/audio_uart_packetizer.sv
// audio_uart_packetizer
//   Captures one multi-channel audio frame per rising edge of audio_valid_in
//   (top BYTES_PER_SAMPLE bytes of each channel, channel 0 first), buffers
//   frames in a FIFO and sends each one to a byte-wide UART transmitter as
//   a packet: SYNC_BYTE followed by the payload bytes, MSB-first.
//
//   Optional feature, macro PACKET_CHECKSUM_EN: when defined, a checksum byte
//   follows the payload. It is the XOR of all payload bytes; SYNC_BYTE is
//   not included.
//
// Ports
//   clk_in              system clock
//   rst_in              asynchronous active-high reset
//   audio_in            per-channel samples, stable while audio_valid_in is high
//   audio_valid_in      level valid; one frame per rising edge
//   enable_in           capture gate
//   uart_busy_in        transmitter busy
//   uart_data_out       byte to the transmitter (held between strobes)
//   uart_trigger_out    single-cycle send strobe
//   fifo_level_out      frames currently buffered
//   overflow_count_out  frames dropped on a full FIFO (saturating)
//   packet_active_out   high while a packet is being sent
module audio_uart_packetizer #(
  parameter int         CHANNELS         = 2,
  parameter int         SAMPLE_WIDTH     = 24,
  parameter int         BYTES_PER_SAMPLE = 2,
  parameter int         FIFO_DEPTH       = 8,
  parameter logic [7:0] SYNC_BYTE        = 8'hA5
) (
  input  logic                                    clk_in,
  input  logic                                    rst_in,
  input  logic [CHANNELS-1:0][SAMPLE_WIDTH-1:0]   audio_in,
  input  logic                                    audio_valid_in,
  input  logic                                    enable_in,
  input  logic                                    uart_busy_in,
  output logic [7:0]                              uart_data_out,
  output logic                                    uart_trigger_out,
  output logic [$clog2(FIFO_DEPTH):0]             fifo_level_out,
  output logic [15:0]                             overflow_count_out,
  output logic                                    packet_active_out
);

  localparam int SLICE_W   = 8 * BYTES_PER_SAMPLE;
  localparam int FRAME_W   = CHANNELS * SLICE_W;
  localparam int PAY_BYTES = CHANNELS * BYTES_PER_SAMPLE;
`ifdef PACKET_CHECKSUM_EN
  localparam int PKT_BYTES = PAY_BYTES + 2;
`else
  localparam int PKT_BYTES = PAY_BYTES + 1;
`endif
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int IW = $clog2(PKT_BYTES + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(PKT_BYTES - 1);
  localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GUARD, S_WAIT} state_t;

  logic [FRAME_W-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]      r_wr;
  logic [PW-1:0]      r_rd;
  logic [LW-1:0]      r_level;
  logic [15:0]        r_ovf;
  logic               r_prev;
  state_t             r_state;
  logic [IW-1:0]      r_idx;
  logic [FRAME_W-1:0] r_shift;
  logic [7:0]         r_data;
  logic               r_trig;
  logic               r_active;
`ifdef PACKET_CHECKSUM_EN
  logic [7:0]         r_csum;
`endif

  logic [FRAME_W-1:0] w_frame;
  logic               w_push_req;
  logic               w_full;
  logic               w_pop;
  logic               w_push;
  logic               w_drop;
  logic [7:0]         w_pay_byte;
  logic               w_unused_lsbs;

  // Channel 0 lands in the top slice so the frame shifts out MSB-first.
  always_comb begin
    w_frame = '0;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      w_frame[FRAME_W-1-ch*SLICE_W -: SLICE_W] = audio_in[ch][SAMPLE_WIDTH-1 -: SLICE_W];
    end
  end

  // Sample bits below the transmitted bytes are intentionally discarded.
  assign w_unused_lsbs = &{1'b0, audio_in};

  assign w_push_req = audio_valid_in & ~r_prev & enable_in;
  assign w_full     = (r_level == FULL_LVL);
  assign w_pop      = (r_state == S_IDLE) && (r_level != '0);
  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign w_push     = w_push_req & (~w_full | w_pop);
  assign w_drop     = w_push_req & w_full & ~w_pop;
  assign w_pay_byte = r_shift[FRAME_W-1 -: 8];

  // On a full push+pop r_wr equals r_rd; the pop reads the old entry.
  always_ff @(posedge clk_in) begin
    if (w_push) r_mem[r_wr] <= w_frame;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_prev   <= 1'b1;   // a level already high at release is not an edge
      r_wr     <= '0;
      r_rd     <= '0;
      r_level  <= '0;
      r_ovf    <= '0;
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_shift  <= '0;
      r_data   <= '0;
      r_trig   <= 1'b0;
      r_active <= 1'b0;
`ifdef PACKET_CHECKSUM_EN
      r_csum   <= '0;
`endif
    end else begin
      r_prev <= audio_valid_in;
      r_trig <= 1'b0;
      if (w_push) r_wr <= r_wr + PW'(1);
      if (w_drop && (r_ovf != 16'hFFFF)) r_ovf <= r_ovf + 16'd1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: ;
      endcase

      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_shift  <= r_mem[r_rd];
            r_rd     <= r_rd + PW'(1);
            r_idx    <= '0;
            r_active <= 1'b1;
            r_state  <= S_SEND;
`ifdef PACKET_CHECKSUM_EN
            r_csum   <= '0;
`endif
          end
        end
        S_SEND: begin
          if (!uart_busy_in) begin
            r_trig  <= 1'b1;
            r_state <= S_GUARD;
            if (r_idx == '0) begin
              r_data <= SYNC_BYTE;
`ifdef PACKET_CHECKSUM_EN
            end else if (r_idx == LAST_IDX) begin
              r_data <= r_csum;
`endif
            end else begin
              r_data  <= w_pay_byte;
              r_shift <= r_shift << 8;
`ifdef PACKET_CHECKSUM_EN
              r_csum  <= r_csum ^ w_pay_byte;
`endif
            end
          end
        end
        // The transmitter raises busy one cycle after the strobe, so busy
        // is not trustworthy here.
        S_GUARD: r_state <= S_WAIT;
        S_WAIT: begin
          if (!uart_busy_in) begin
            if (r_idx == LAST_IDX) begin
              r_active <= 1'b0;
              r_state  <= S_IDLE;
            end else begin
              r_idx   <= r_idx + IW'(1);
              r_state <= S_SEND;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign uart_data_out      = r_data;
  assign uart_trigger_out   = r_trig;
  assign fifo_level_out     = r_level;
  assign overflow_count_out = r_ovf;
  assign packet_active_out  = r_active;

endmodule

// File: tb/tb_audio_uart_packetizer.sv
// Testbench for audio_uart_packetizer: directed scenarios plus randomized
// traffic, with a packet-level reference model compared every cycle.
module tb_audio_uart_packetizer;
  localparam int CH    = 2;
  localparam int SW    = 24;
  localparam int BPS   = 2;
  localparam int DEPTH = 8;
  localparam logic [7:0] SYNC = 8'hA5;
  localparam int PAY = CH * BPS;
`ifdef PACKET_CHECKSUM_EN
  localparam int PLEN = PAY + 2;
`else
  localparam int PLEN = PAY + 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [CH-1:0][SW-1:0] aud = '0;
  logic valid = 1'b0;
  logic enable = 1'b1;
  logic busy = 1'b0;
  logic [7:0] uart_data;
  logic uart_trig;
  logic active;
  logic [$clog2(DEPTH):0] level;
  logic [15:0] ovf;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  // transmitter model controls
  int K = 20;
  int tx_cnt = 0;
  logic pend = 1'b0;
  logic force_busy = 1'b0;

  // observation
  logic [7:0] log_q[$];
  int n_trig = 0;
  int first_trig_cyc = -1;
  int peak = 0;
  int edge_cyc = 0;

  // reference model state
  logic m_prev = 1'b1;
  logic [7:0] m_fifo_b[$];
  int m_nfr = 0;
  logic [7:0] m_pkt[$];
  logic m_on = 1'b0;
  logic m_may_send = 1'b0;
  logic m_guard = 1'b0;
  logic m_trig = 1'b0;
  logic [7:0] m_data = 8'h00;
  logic [15:0] m_ovf = 16'h0000;
  logic mb_push;
  logic mb_pop;
  logic [7:0] mb_csum;
  logic [7:0] mb_b;
  logic [SW-1:0] mb_s;

  logic [7:0] exp_basic [6];

  audio_uart_packetizer #(
    .CHANNELS(CH), .SAMPLE_WIDTH(SW), .BYTES_PER_SAMPLE(BPS),
    .FIFO_DEPTH(DEPTH), .SYNC_BYTE(SYNC)
  ) dut (
    .clk_in(clk), .rst_in(rst), .audio_in(aud), .audio_valid_in(valid),
    .enable_in(enable), .uart_busy_in(busy), .uart_data_out(uart_data),
    .uart_trigger_out(uart_trig), .fifo_level_out(level),
    .overflow_count_out(ovf), .packet_active_out(active)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // UART transmitter: busy rises one cycle after a strobe and lasts K cycles.
  initial forever begin
    @(posedge clk);
    #2;
    if (tx_cnt > 0) tx_cnt--;
    if (pend) tx_cnt = K;
    pend = uart_trig;
    busy = force_busy || (tx_cnt > 0);
  end

  // Reference model: frames are byte lists; a packet is SYNC + payload
  // (+ XOR), sent one byte per handshake.
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_prev = 1'b1;
      m_fifo_b.delete();
      m_nfr = 0;
      m_pkt.delete();
      m_on = 1'b0;
      m_may_send = 1'b0;
      m_guard = 1'b0;
      m_trig = 1'b0;
      m_data = 8'h00;
      m_ovf = 16'h0000;
    end else begin
      mb_push = valid && !m_prev && enable;
      m_prev = valid;
      mb_pop = !m_on && (m_nfr > 0);
      m_trig = 1'b0;
      if (mb_pop) begin
        m_pkt.delete();
        m_pkt.push_back(SYNC);
        mb_csum = 8'h00;
        for (int k = 0; k < PAY; k++) begin
          mb_b = m_fifo_b.pop_front();
          m_pkt.push_back(mb_b);
          mb_csum = mb_csum ^ mb_b;
        end
`ifdef PACKET_CHECKSUM_EN
        m_pkt.push_back(mb_csum);
`endif
        m_nfr--;
        m_on = 1'b1;
        m_may_send = 1'b1;
      end else if (m_on) begin
        if (m_may_send) begin
          if (!busy) begin
            m_data = m_pkt.pop_front();
            m_trig = 1'b1;
            m_may_send = 1'b0;
            m_guard = 1'b1;
          end
        end else if (m_guard) begin
          m_guard = 1'b0;
        end else if (!busy) begin
          if (m_pkt.size() == 0) m_on = 1'b0;
          else m_may_send = 1'b1;
        end
      end
      if (mb_push) begin
        if (m_nfr < DEPTH) begin
          for (int ch = 0; ch < CH; ch++) begin
            mb_s = aud[ch];
            for (int b = 0; b < BPS; b++) begin
              mb_b = 8'(mb_s >> (SW - 8 * (b + 1)));
              m_fifo_b.push_back(mb_b);
            end
          end
          m_nfr++;
        end else if (m_ovf != 16'hFFFF) begin
          m_ovf = m_ovf + 16'd1;
        end
      end
    end
  end

  // Compare process: every output against the model, every cycle.
  initial forever begin
    @(negedge clk);
    chk("trigger", uart_trig, m_trig);
    chk("data", uart_data, m_data);
    chk("active", active, m_on);
    chk("level", level, m_nfr);
    chk("overflow", ovf, m_ovf);
  end

  // Observation of strobes and occupancy.
  initial forever begin
    @(negedge clk);
    if (uart_trig) begin
      log_q.push_back(uart_data);
      n_trig++;
      if (first_trig_cyc < 0) first_trig_cyc = cyc;
    end
    if (int'(level) > peak) peak = int'(level);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    valid = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    repeat (2) tick();
  endtask

  task automatic pulse_valid();
    valid = 1'b1;
    tick();
    valid = 1'b0;
    tick();
  endtask

  task automatic wait_idle(input int max_cyc);
    int n;
    n = 0;
    while (!(!m_on && m_nfr == 0 && tx_cnt == 0 && !pend) && n < max_cyc) begin
      tick();
      n++;
    end
    if (n >= max_cyc) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_idle: timeout after %0d cycles", max_cyc);
    end
    repeat (2) tick();
  endtask

  task automatic wait_trig(input int cnt, input int max_cyc);
    int n;
    n = 0;
    while (n_trig < cnt && n < max_cyc) begin
      tick();
      n++;
    end
    if (n >= max_cyc) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_trig: got %0d strobes expected %0d", n_trig, cnt);
    end
  endtask

  initial begin
    int n;
    exp_basic[0] = 8'hA5; exp_basic[1] = 8'h12; exp_basic[2] = 8'h34;
    exp_basic[3] = 8'hAB; exp_basic[4] = 8'hCD; exp_basic[5] = 8'h40;

    // reset state
    do_reset();
    chk("reset_data", uart_data, 8'h00);
    chk("reset_trig", uart_trig, 1'b0);
    chk("reset_level", level, 0);
    chk("reset_ovf", ovf, 16'h0000);
    chk("reset_active", active, 1'b0);

    // basic packet and first-strobe latency
    K = 20;
    aud[0] = 24'h123456;
    aud[1] = 24'hABCDEF;
    log_q.delete();
    first_trig_cyc = -1;
    edge_cyc = cyc + 1;
    pulse_valid();
    wait_idle(600);
    chk("basic_len", log_q.size(), PLEN);
    for (int i = 0; i < PLEN; i++) begin
      if (i < log_q.size()) chk("basic_byte", log_q[i], exp_basic[i]);
    end
    chk("basic_latency", first_trig_cyc - edge_cyc, 2);

    // level hold: one packet only
    do_reset();
    peak = 0;
    n_trig = 0;
    aud[0] = 24'($urandom);
    aud[1] = 24'($urandom);
    valid = 1'b1;
    repeat (50) tick();
    valid = 1'b0;
    wait_idle(600);
    chk("hold_strobes", n_trig, PLEN);
    chk("hold_peak", peak, 1);

    // overflow with busy held high, then full push+pop
    do_reset();
    force_busy = 1'b1;
    n_trig = 0;
    for (int i = 0; i < 10; i++) begin
      aud[0] = 24'($urandom);
      aud[1] = 24'($urandom);
      pulse_valid();
    end
    tick();
    chk("ovf_level", level, 8);
    chk("ovf_count", ovf, 16'd1);
    chk("ovf_no_strobe", n_trig, 0);
    force_busy = 1'b0;
    n = 0;
    while (!(!m_on && m_nfr == DEPTH) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      n_vec++;
      n_err++;
      $display("FAIL full_pop_wait: engine never idle with full FIFO");
    end
    aud[0] = 24'($urandom);
    aud[1] = 24'($urandom);
    valid = 1'b1;
    @(posedge clk);
    #1;
    valid = 1'b0;
    @(negedge clk);
    chk("fullpp_level", level, 8);
    chk("fullpp_ovf", ovf, 16'd1);
    wait_idle(4000);
    chk("ovf_drain_strobes", n_trig, 10 * PLEN);

    // enable gate
    do_reset();
    enable = 1'b0;
    n_trig = 0;
    for (int i = 0; i < 3; i++) pulse_valid();
    repeat (5) tick();
    chk("gate_strobes", n_trig, 0);
    chk("gate_ovf", ovf, 16'd0);
    chk("gate_level", level, 0);
    enable = 1'b1;
    pulse_valid();
    wait_trig(2, 200);
    enable = 1'b0;
    wait_idle(600);
    chk("gate_drop_complete", n_trig, PLEN);
    enable = 1'b1;

    // async reset mid-packet
    do_reset();
    n_trig = 0;
    aud[0] = 24'($urandom);
    aud[1] = 24'($urandom);
    pulse_valid();
    wait_trig(2, 200);
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b1;
    valid = 1'b1;
    #1;
    chk("arst_data", uart_data, 8'h00);
    chk("arst_trig", uart_trig, 1'b0);
    chk("arst_level", level, 0);
    chk("arst_active", active, 1'b0);
    chk("arst_ovf", ovf, 16'h0000);
    tick();
    rst = 1'b0;
    n_trig = 0;
    repeat (40) tick();
    chk("arst_no_packet", n_trig, 0);
    valid = 1'b0;
    tick();
    log_q.delete();
    pulse_valid();
    wait_idle(600);
    chk("arst_new_len", log_q.size(), PLEN);
    if (log_q.size() > 0) chk("arst_new_sync", log_q[0], SYNC);

    // randomized traffic
    do_reset();
    K = $urandom_range(0, 6);
    for (int i = 0; i < 3000; i++) begin
      if (!valid) begin
        aud[0] = 24'($urandom);
        aud[1] = 24'($urandom);
      end
      if ($urandom_range(0, 3) == 0) valid = ~valid;
      enable = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 63) == 0) force_busy = ~force_busy;
      tick();
    end
    valid = 1'b0;
    enable = 1'b1;
    force_busy = 1'b0;
    wait_idle(8000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/audio_uart_packetizer.md
Name: audio_uart_packetizer

Overview:
- Multi-channel successor to the single-channel 16-bit audio→UART streaming path.
- Captures one frame per rising edge of audio_valid_in: all CHANNELS samples, top BYTES_PER_SAMPLE bytes of each.
- Buffers frames in a FIFO and serialises each as a framed byte packet into the existing 8-bit UART transmitter using the trigger/busy handshake.
- Sits between tdm_receive and the UART transmitter in the beamforming top level.

Parameters:
- CHANNELS, 2, number of mic slots per frame (1..8).
- SAMPLE_WIDTH, 24, bits per input sample.
- BYTES_PER_SAMPLE, 2, bytes sent per sample, taken MSB-first from the top of the sample (1..SAMPLE_WIDTH/8).
- FIFO_DEPTH, 8, frames buffered; power of two.
- SYNC_BYTE, 8'hA5, first byte of every packet.

Ports:
- clk_in  input  1  system clock (100 MHz).
- rst_in  input  1  reset; asynchronous, active-high.
- audio_in  input  [CHANNELS][SAMPLE_WIDTH]  per-channel samples; stable while audio_valid_in is high.
- audio_valid_in  input  1  level valid, already synchronised to clk_in; one frame per rising edge.
- enable_in  input  1  capture gate (switch).
- uart_busy_in  input  1  busy from the UART transmitter.
- uart_data_out  output  8  byte to the transmitter.
- uart_trigger_out  output  1  single-cycle send strobe.
- fifo_level_out  output  $clog2(FIFO_DEPTH)+1  frames currently buffered.
- overflow_count_out  output  16  frames dropped because the FIFO was full; saturates at 16'hFFFF.
- packet_active_out  output  1  high while a packet is being sent.

Behaviour:
- Reset (async assert, values apply immediately):
  - All outputs 0.
  - FIFO empty; FSM IDLE.
  - Edge-detect register resets to 1, so a level already high at reset release is not a frame.
- Edge detect: push request = audio_valid_in & ~prev & enable_in. While enable_in is low, frames are ignored and not counted as overflow.
- Frame word:
  - Width CHANNELS*8*BYTES_PER_SAMPLE.
  - Channel 0 first; each slice is audio_in[ch][SAMPLE_WIDTH-1 -: 8*BYTES_PER_SAMPLE].
  - Captured on the push cycle.
- FIFO:
  - Push while not full: write, level+1.
  - Push while full with no pop that cycle: frame dropped, overflow_count_out+1 (saturating).
  - Push and pop in the same cycle while full: push accepted, level unchanged.
  - Pop on empty never occurs.
- FSM:
  - IDLE: if FIFO non-empty, pop the frame into a shift register, clear the byte index → SEND.
  - SEND: wait until uart_busy_in is 0.
    - Drive uart_data_out with the current byte (SYNC_BYTE, then payload bytes in order).
    - Pulse uart_trigger_out for exactly 1 cycle → GUARD.
  - GUARD: 1 cycle; uart_busy_in ignored because the transmitter raises busy one cycle after trigger → WAIT.
  - WAIT: when uart_busy_in is 0:
    - If the last byte was sent → IDLE.
    - Otherwise advance the index → SEND.
- uart_data_out holds its value between strobes.
- packet_active_out is high in every state except IDLE.
- Packet length: 1 + CHANNELS*BYTES_PER_SAMPLE bytes (+1 with the optional feature).
- Latency: with edge on cycle N, FIFO empty, FSM idle and busy low: frame is in the FIFO after edge N, pop happens at N+1, first trigger at N+2.
- Back-to-back packets: IDLE → SEND costs 1 cycle; no gap bytes are inserted.
- A packet in flight always completes even if enable_in drops, except on reset.
- Reset mid-packet: output returns to 0 immediately and the packet is abandoned. The transmitter may finish its current byte; the host resynchronises on SYNC_BYTE.

Optional Feature:
- Macro: PACKET_CHECKSUM_EN.
- Defined: one extra byte after the payload, equal to the XOR of all payload bytes (SYNC excluded); sent with the same handshake.
- Undefined: no checksum byte; packet ends after the last payload byte.

Test Plan:
- Basic packet: CHANNELS=2, BPS=2, audio_in={24'h123456, 24'hABCDEF}, one rising edge, busy modelled (high 1 cycle after trigger for 20 cycles) → strobes carry A5,12,34,AB,CD. With PACKET_CHECKSUM_EN, a 6th byte 40. First trigger 2 cycles after the edge.
- Level hold: audio_valid_in held high 50 cycles → exactly one packet; fifo_level_out peaks at 1.
- Overflow: uart_busy_in forced high, 10 edges with FIFO_DEPTH=8 → after the first pop, fifo_level_out=8 and overflow_count_out=1. Release busy → 9 complete packets in arrival order.
- Full push+pop: FIFO full, edge coincident with the IDLE pop → no overflow increment; level stays 8.
- Enable gate: enable_in=0, 3 edges → no triggers, overflow 0. Drop enable mid-packet → packet finishes.
- Async reset mid-packet: assert rst_in between payload bytes, off a clock edge → all outputs 0 without waiting for an edge. Valid high across release → no packet. Next fresh edge → full packet starting A5.
